// File: rtl/aes_mixcolumns_fwd_iter.sv
// Iterative forward AES MixColumns: one 128-bit state in, COLS_PER_CYCLE columns
// transformed in place per cycle, result handed out over a valid/ready pair.
module aes_mixcolumns_fwd_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCYC = (COLS_PER_CYCLE == 1) ? 4 :
                          (COLS_PER_CYCLE == 2) ? 2 : 1;
    localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("aes_mixcolumns_fwd_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   cnt;
    logic         bypass;
    logic [127:0] data;
    logic [127:0] data_next;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Column c belongs to iteration c/COLS_PER_CYCLE, so lower columns are done first.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic col_sel;
        assign col_sel = (cnt == 2'(c / COLS_PER_CYCLE)) && !bypass;
        assign data_next[127-32*c -: 32] = col_sel ? mix_col(data[127-32*c -: 32])
                                                   : data[127-32*c -: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = BUSY;
            BUSY:    if (cnt == LAST_CNT) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == BUSY) || (state == DONE);
    end

    // Bypass still walks through every BUSY cycle so both paths share one latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            data   <= 128'h0;
            cnt    <= 2'd0;
            bypass <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    if (in_valid) begin
                        data   <= in_state;
                        bypass <= in_bypass;
                    end
                end
                BUSY: begin
                    data <= data_next;
                    cnt  <= cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_state = data;

endmodule
